// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and fetches over req/ack; define PC_ALIGN_CHECK_EN to trap misaligned redirects to TRAP_PC.
// Latency: instr_valid one cycle after imem_ack. Stall or !instr_ready holds instr and pc in HOLD; timeout after MAX_WAIT unacked cycles.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        timeout,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        accept;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign accept   = (state_q == ST_HOLD) && instr_ready && !stall;

    // Redirect priority: jump beats branch beats sequential.
    always_comb begin
        redirect_pc = pc_plus4;
        if (jump) begin
            redirect_pc = jump_target;
        end else if (br_taken) begin
            redirect_pc = br_target;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic redirect_misaligned;
    logic misalign_q, misalign_d;

    always_comb begin
        redirect_misaligned = |redirect_pc[1:0];
        next_pc             = redirect_misaligned ? TRAP_PC : redirect_pc;
    end

    // Pulse lands in the cycle right after the accepting edge.
    assign misalign_d = accept && redirect_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_trap_pc;

    assign next_pc        = redirect_pc & 32'hFFFF_FFFC;
    assign misalign       = 1'b0;
    assign unused_trap_pc = ^TRAP_PC;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        timeout_d     = timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = 8'd0;
                if (start) begin
                    state_d   = ST_REQ;
                    timeout_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    wait_cnt_d    = 8'd0;
                    state_d       = ST_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    // Give up on the fetch; pc is kept so a restart retries it.
                    if (wait_cnt_d == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            timeout_q     <= timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the 32-bit CPU datapath.
- Computes PC+4 internally and selects the next PC with priority jump > branch > PC+4.
- Drives a req/ack handshake to instruction memory.
- Presents fetched instructions to decode with a valid/ready handshake, and supports stall and a fetch timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0080, PC loaded on a misaligned redirect (only when PC_ALIGN_CHECK_EN is defined).
- MAX_WAIT, 15, maximum REQ cycles without imem_ack before timeout (range 1..255).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from IDLE.
- stall  in  1  hold the current instruction; blocks PC update.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  fetch address (equals pc).
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- instr  out  32  registered instruction to decode.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  decode accepts instr.
- br_taken  in  1  branch redirect request.
- br_target  in  32  branch target.
- jump  in  1  jump redirect request.
- jump_target  in  32  jump target.
- pc  out  32  current PC register.
- pc_plus4  out  32  combinational pc + 32'd4.
- timeout  out  1  sticky fetch-timeout flag.
- misalign  out  1  one-cycle misaligned-redirect pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, timeout=0, misalign=0, wait counter=0. imem_req drops immediately, mid-transaction included. Any outstanding ack is ignored after release.
- pc_plus4 = pc + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). No carry out.
- imem_addr = pc at all times. imem_req=1 only in REQ.
- IDLE: wait counter cleared. start=1 -> REQ next cycle and timeout cleared. start outside IDLE is ignored.
- REQ:
  - imem_ack=1 -> instr<=imem_rdata, instr_valid<=1, counter<=0, go HOLD. Zero-wait memory gives instr_valid one cycle after REQ entry.
  - Else counter increments. When counter reaches MAX_WAIT: timeout<=1, go IDLE, pc unchanged.
- HOLD: instr_valid=1, instr stable.
  - Accept only when instr_ready=1 and stall=0. In that cycle, sample redirects:
    - jump=1: next=jump_target (wins over br_taken).
    - else br_taken=1: next=br_target.
    - else next=pc_plus4.
  - On accept: pc<=next, instr_valid<=0, go REQ.
  - stall=1 holds HOLD regardless of instr_ready. Redirects are ignored when not accepting.
- Throughput: 1 instruction per 2 cycles with zero-wait memory and ready=1.
- Redirect low bits are handled per the optional feature.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: if the selected next PC has [1:0]!=2'b00, pc<=TRAP_PC instead, and misalign=1 for exactly the cycle after the accepting edge. Sequencing then continues normally (REQ at TRAP_PC).
- Undefined: next PC is loaded with bits [1:0] forced to 2'b00, misalign tied to 0, and TRAP_PC is unused.
- The port list is identical in both builds.

Test Plan:
1. Reset then start, with zero-wait memory returning imem_rdata=32'h2008_0005 and instr_ready=1 held high:
   - imem_addr sequence 0x0, 0x4, 0x8.
   - instr_valid high every other cycle.
   - instr=32'h2008_0005.
2. In HOLD at pc=0x10, assert jump=1 with jump_target=0x40 and br_taken=1 with br_target=0x80, together with instr_ready=1 -> next imem_addr=0x40.
3. Hold stall=1 for 3 cycles in HOLD with instr_ready=1 and br_taken=1, br_target=0x20:
   - pc holds and instr stays stable.
   - Release stall with br_taken=0 -> pc=pc+4.
4. Never assert imem_ack with MAX_WAIT=15 -> timeout=1 after 15 REQ cycles, state IDLE, imem_req=0. A following start clears timeout.
5. pc=0xFFFF_FFFC, accepted with no redirect -> pc wraps to 0x0000_0000.
6. Assert rst_n=0 mid-REQ at pc=0x24 -> imem_req=0 asynchronously, pc=RESET_PC. With PC_ALIGN_CHECK_EN defined, jump_target=0x42 -> pc=0x80 and misalign pulses 1 cycle.
